// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART block.
// Holds register offsets, the decode mask, status bit positions, the TX
// serializer state encoding and a small address-hit helper used by the top.
package pref_defines;

  localparam logic [31:0] UART_DATA_OFF  = 32'h0;
  localparam logic [31:0] UART_STAT_OFF  = 32'h4;
  localparam logic [31:0] UART_ADDR_MASK = 32'h0000_000C;

  localparam int unsigned UART_ST_BUSY  = 0;
  localparam int unsigned UART_ST_FULL  = 1;
  localparam int unsigned UART_ST_EMPTY = 2;
  localparam int unsigned UART_ST_OVF   = 3;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_tx_state_t;

  // Only addr[3:0] takes part in decode: the word index comes from the mask
  // bits and the byte-lane bits must be zero.
  function automatic logic uart_hit(input logic [31:0] a, input logic [31:0] off);
    return ((a & UART_ADDR_MASK) == off) && (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Bus-side register interface of the UART peripheral.
//   wr_en/rd_en : strobes already qualified for this peripheral
//   addr        : byte offset from the peripheral base
//   data_in     : write data
//   data_out    : registered read data
// master = bridge side, slave = peripheral side.
interface uart_tx_mmio_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output wr_en, rd_en, addr, data_in,
    input  data_out
  );

  modport slave (
    input  wr_en, rd_en, addr, data_in,
    output data_out
  );
endinterface

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous FIFO used by the UART TX path (and reusable for RX).
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write an entry (ignored when full unless a pop happens too)
//   pop      : remove the head entry (ignored when empty)
//   dout     : head entry, combinational, valid while not empty
//   full, empty, count : occupancy
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : register interface (slave); stores at UART_DATA_OFF queue a
//              byte, reads at UART_STAT_OFF return busy/full/empty/overflow
//              and FIFO count, every other read returns 0
//   tx       : registered serial output, idle high
module uart_tx_mmio
  import pref_defines::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_mmio_if.slave  bus,
  output logic           tx
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           ovf_q, ovf_d;
  logic [31:0]    dout_q, dout_d;

  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  fifo_count;

  logic           wr_data, rd_stat, ovf_wr, baud_end;
  logic [31:0]    stat;
  logic           unused_data_in;

  assign unused_data_in = ^bus.data_in[31:8];

  assign wr_data   = bus.wr_en && uart_hit(bus.addr, UART_DATA_OFF);
  assign rd_stat   = bus.rd_en && uart_hit(bus.addr, UART_STAT_OFF);
  assign fifo_push = wr_data;
  assign ovf_wr    = wr_data && fifo_full && !fifo_pop;
  assign baud_end  = (baud_q == BW'(DIV - 1));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.data_in[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      UART_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          bit_d    = '0;
          baud_d   = '0;
          state_d  = UART_START;
        end
      end
      UART_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = UART_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      UART_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      UART_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            bit_d    = '0;
            state_d  = UART_START;
          end else begin
            state_d = UART_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = UART_IDLE;
    endcase

    // tx is registered from the next state, so the line level changes on
    // the same edge as the state it belongs to.
    unique case (state_d)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shift_d[0];
      default:    tx_d = 1'b1;
    endcase
  end

  always_comb begin
    stat                = '0;
    stat[UART_ST_BUSY]  = (state_q != UART_IDLE);
    stat[UART_ST_FULL]  = fifo_full;
    stat[UART_ST_EMPTY] = fifo_empty;
    stat[UART_ST_OVF]   = ovf_q;
    stat[8 +: CW]       = fifo_count;
  end

  always_comb begin
    dout_d = dout_q;
    if (bus.rd_en) dout_d = rd_stat ? stat : '0;
    // A dropped write in the same cycle as the clearing read wins.
    ovf_d = ovf_q;
    if (rd_stat) ovf_d = 1'b0;
    if (ovf_wr)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
    end
  end

  assign tx           = tx_q;
  assign bus.data_out = dout_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio with DIV = 4 (CLK_FREQ=4, BAUD=1).
// Stimulus pushes expected read data and expected transmitted bytes into
// queues; independent monitors pop and compare when the DUT responds.
module tb_uart_tx_mmio;
  import pref_defines::*;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  logic tx;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .CLK_FREQ   (4),
    .BAUD       (1),
    .FIFO_DEPTH (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] rd_q [$];
  logic [7:0]  tx_q [$];
  int          start_q [$];
  int          frames_done = 0;
  int          cyc = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got unexpected DUT response, expected none", name);
  endfunction

  // Read monitor: data_out is checked one edge after rd_en is sampled.
  always @(posedge clk) begin
    if (rst === 1'b0 && bus.rd_en === 1'b1) begin
      #1;
      if (rd_q.size() == 0) fail("rd_unexpected");
      else check("rd_data", bus.data_out, rd_q.pop_front());
    end
  end

  // TX monitor: samples on the falling edge; a frame is exactly 10*DIV
  // samples: DIV low, 8 data bits of DIV samples each (LSB first), DIV high.
  logic       in_frame = 1'b0;
  logic       have_exp;
  logic       bad;
  logic [7:0] rx;
  logic [7:0] exp_b;
  int         pos;

  always @(negedge clk) begin
    int b;
    cyc++;
    if (rst !== 1'b0) begin
      in_frame = 1'b0;
    end else begin
      if (in_frame) begin
        pos++;
      end else if (tx === 1'b0) begin
        in_frame = 1'b1;
        pos      = 0;
        bad      = 1'b0;
        rx       = '0;
        start_q.push_back(cyc);
        if (tx_q.size() == 0) begin
          have_exp = 1'b0;
          fail("tx_unexpected_frame");
        end else begin
          have_exp = 1'b1;
          exp_b    = tx_q.pop_front();
        end
      end
      if (in_frame) begin
        b = pos / DIV;
        if (b == 0) begin
          if (tx !== 1'b0) bad = 1'b1;
        end else if (b == 9) begin
          if (tx !== 1'b1) bad = 1'b1;
        end else if (pos % DIV == 0) begin
          rx[b-1] = tx;
        end else if (tx !== rx[b-1]) begin
          bad = 1'b1;
        end
        if (pos == 10*DIV - 1) begin
          in_frame = 1'b0;
          frames_done++;
          if (have_exp) check("tx_frame{bad,byte}", {23'b0, bad, rx}, {23'b0, 1'b0, exp_b});
        end
      end
    end
  end

  // All tasks start and end on a falling edge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 check("rst_tx_immediate", {31'b0, tx}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data_out", bus.data_out, 32'h0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'b0, tx}, 32'h1);
    check("reset_data_out", bus.data_out, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Decode: status, unmapped, data-register reads; write to 0x8 ignored.
    bus_rd(UART_STAT_OFF, 32'h0000_0004);
    bus_rd(32'h8, 32'h0);
    bus_rd(UART_STAT_OFF, 32'h0000_0004);
    bus_rd(UART_DATA_OFF, 32'h0);
    bus_wr(32'h8, 32'h0000_00AB);
    bus_rd(UART_STAT_OFF, 32'h0000_0004);

    // Single frame 0x55; status read on the pop edge still sees idle, count 1.
    tx_q.push_back(8'h55);
    bus_wr(UART_DATA_OFF, 32'h0000_0155);
    check("pre_pop_tx", {31'b0, tx}, 32'h1);
    bus_rd(UART_STAT_OFF, 32'h0000_0100);
    check("post_pop_tx", {31'b0, tx}, 32'h0);
    idle(10);
    bus_rd(UART_STAT_OFF, 32'h0000_0005);
    idle(28);
    bus_rd(UART_STAT_OFF, 32'h0000_0005);   // last cycle of the stop bit
    bus_rd(UART_STAT_OFF, 32'h0000_0004);   // back to idle

    // Back-to-back frames with no idle gap.
    start_q.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h3C);
    bus_wr(UART_DATA_OFF, 32'hA5);
    bus_wr(UART_DATA_OFF, 32'h3C);
    idle(90);
    check("b2b_frame_count", start_q.size(), 32'd2);
    if (start_q.size() >= 2) check("b2b_start_spacing", start_q[1] - start_q[0], 32'd40);

    // Overflow: keep the serializer busy, fill 16 entries, then a 17th.
    tx_q.push_back(8'h11);
    bus_wr(UART_DATA_OFF, 32'h11);
    idle(2);
    for (int i = 0; i < 16; i++) begin
      tx_q.push_back(8'h80 + i[7:0]);
      bus_wr(UART_DATA_OFF, 32'h80 + i);
    end
    bus_wr(UART_DATA_OFF, 32'hEE);
    bus_rd(UART_STAT_OFF, 32'h0000_100B);   // busy, full, ovf, count 16
    bus_rd(UART_STAT_OFF, 32'h0000_1003);   // ovf cleared by previous read
    idle(17 * 40);
    bus_rd(UART_STAT_OFF, 32'h0000_0004);

    // Reset during the start bit (tx low) abandons the frame.
    tx_q.push_back(8'h00);
    bus_wr(UART_DATA_OFF, 32'h00);
    idle(1);
    check("start_bit_low", {31'b0, tx}, 32'h0);
    pulse_reset();
    bus_rd(UART_STAT_OFF, 32'h0000_0004);

    // Reset in the middle of the data bits of 0xFF.
    tx_q.push_back(8'hFF);
    bus_wr(UART_DATA_OFF, 32'hFF);
    idle(12);
    pulse_reset();
    idle(50);
    bus_rd(UART_STAT_OFF, 32'h0000_0004);

    idle(2);
    check("tx_queue_drained", tx_q.size(), 32'd0);
    check("rd_queue_drained", rd_q.size(), 32'd0);
    check("frames_completed", frames_done, 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected run to complete");
    $fatal(1, "watchdog");
  end

endmodule
